pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Parametrised program-counter sequencer; next generation of the core PC register.
- Adds async reset to a configurable vector, configurable width and step, and vectored interrupt entry/return with a saved EPC and a handshake.
- Adds target-alignment checking.
- Sits between the control unit (drives pc_op/next_pc) and instruction fetch (consumes pc); interrupt controller drives int_req/int_id.

Parameters:
- XLEN, 32, PC/address width.
- RESET_VEC, 32'h0000_0000, PC value on rst_n low and on op RESET.
- INT_BASE, 32'h0000_0100, interrupt vector table base.
- NUM_INT, 8, number of interrupt sources (>=2).
- VEC_STRIDE, 4, byte distance between vector entries; 0 = all interrupts enter at INT_BASE (direct mode).
- INC_STEP, 4, byte increment for op INC.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_op  in  3  000 NOP, 001 INC, 010 ASSIGN, 011 RESET, 100 MRET, 101-111 illegal.
- next_pc  in  XLEN  target for ASSIGN.
- int_req  in  1  level interrupt request; held until int_ack.
- int_id  in  clog2(NUM_INT)  source index, valid with int_req.
- int_en  in  1  global interrupt enable.
- pc  out  XLEN  current PC (registered).
- epc  out  XLEN  saved return PC (registered).
- in_handler  out  1  1 while executing a handler.
- int_ack  out  1  one-cycle pulse on interrupt entry.
- misalign_err  out  1  one-cycle pulse, rejected ASSIGN target.
- op_err  out  1  one-cycle pulse, illegal op or MRET outside handler.

Behaviour:
- Reset (rst_n low, async): pc=RESET_VEC, epc=0, in_handler=0, int_ack=0, misalign_err=0, op_err=0. All outputs registered; effects visible the cycle after the edge (latency 1).
- Nominal next value nxt from pc_op:
  - NOP: pc.
  - INC: pc+INC_STEP, modulo 2^XLEN (wraps).
  - ASSIGN: next_pc if next_pc[1:0]==0; else pc, with misalign_err=1.
  - MRET: if in_handler, epc and in_handler<=0; else pc, with op_err=1.
  - Illegal op: pc, with op_err=1.
- State machine, two states (RUN when in_handler=0, HANDLER when in_handler=1):
  - RUN -> HANDLER: int_req & int_en & pc_op!=RESET. Then epc<=nxt; pc<=INT_BASE+int_id*VEC_STRIDE (width XLEN, wraps); in_handler<=1; int_ack<=1. Error pulses from the same op still fire.
  - HANDLER -> RUN: MRET only.
  - No nesting: int_req ignored in HANDLER, including the MRET cycle; it can be taken the following cycle.
- Priority: rst_n > op RESET > interrupt entry > ordinary op.
- op RESET: pc=RESET_VEC, in_handler=0, epc unchanged, int_ack suppressed even if int_req is high.
- int_id >= NUM_INT: entry still taken, index masked to clog2(NUM_INT) bits.
- rst_n asserted mid-handler: all state returns to reset values; pending int_req is re-evaluated after release.

Optional Feature:
- Macro PC_SEQ_COMPRESSED_EN.
- Defined:
  - Adds input inst_16 (1 bit).
  - INC steps by 2 when inst_16=1, else INC_STEP.
  - Alignment check relaxes to next_pc[0]==0.
  - epc[0] forced 0.
- Undefined: no inst_16 port; 4-byte alignment as above.

Decomposition:
- Shared package pc_seq_pkg: pc_op_t enum (NOP/INC/ASSIGN/RESET/MRET), PC_OP_W=3, default vector constants.
- Natural sub-module: pc_seq_nxt, combinational nominal-next/error logic. The top module holds the registers, the FSM and interrupt priority.

Test Plan:
- Reset and INC: release rst_n, 3 cycles of INC -> pc 0x0, 0x4, 0x8, 0xC; drop rst_n mid-run -> pc=0x0 immediately (async).
- ASSIGN alignment: ASSIGN 0x2000 -> pc=0x2000. ASSIGN 0x2002 -> pc holds 0x2000, misalign_err pulses once.
- Vectored interrupt: at pc=0x40 with op INC, int_req=1, int_id=3, int_en=1 -> pc=0x10C, epc=0x44, int_ack 1 cycle, in_handler=1. Later MRET -> pc=0x44, in_handler=0.
- No nesting / enable: in handler, int_req=1 int_id=5 -> no ack. int_en=0 in RUN -> no entry. Request held through MRET -> entry on the cycle after MRET.
- Priority and errors:
  - RESET op with int_req=1 -> pc=RESET_VEC, no int_ack.
  - MRET in RUN -> op_err pulse, pc unchanged.
  - Op 111 -> op_err pulse.
- Wrap: pc=0xFFFF_FFFC, INC -> pc=0x0. With PC_SEQ_COMPRESSED_EN: inst_16=1 from 0x100 -> 0x102; ASSIGN 0x102 accepted.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
// Optional compressed-instruction support: PC_SEQ_COMPRESSED_EN.
package pc_seq_pkg;

  localparam int PC_OP_W = 3;

  typedef enum logic [PC_OP_W-1:0] {
    OP_NOP    = 3'b000,
    OP_INC    = 3'b001,
    OP_ASSIGN = 3'b010,
    OP_RESET  = 3'b011,
    OP_MRET   = 3'b100
  } pc_op_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } pc_state_t;

  localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_BASE   = 32'h0000_0100;
  localparam int          DEF_NUM_INT    = 8;
  localparam int          DEF_VEC_STRIDE = 4;
  localparam int          DEF_INC_STEP   = 4;

endpackage

// File: rtl/pc_seq_nxt.sv
// Combinational nominal-next PC and op error decode.
// PC_SEQ_COMPRESSED_EN adds inst_16 and relaxes alignment to 2 bytes.
module pc_seq_nxt
  import pc_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              INC_STEP  = DEF_INC_STEP,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC)
) (
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    epc,
  input  logic [PC_OP_W-1:0] pc_op,
  input  logic [XLEN-1:0]    next_pc,
  input  logic               in_handler,
`ifdef PC_SEQ_COMPRESSED_EN
  input  logic               inst_16,
`endif
  output logic [XLEN-1:0]    nxt,
  output logic               mis_err,
  output logic               op_err,
  output logic               mret_ok
);

  logic            is_nop;
  logic            is_inc;
  logic            is_asg;
  logic            is_rst;
  logic            is_mret;
  logic            aligned;
  logic [XLEN-1:0] step;

  assign is_nop  = pc_op == OP_NOP;
  assign is_inc  = pc_op == OP_INC;
  assign is_asg  = pc_op == OP_ASSIGN;
  assign is_rst  = pc_op == OP_RESET;
  assign is_mret = pc_op == OP_MRET;

`ifdef PC_SEQ_COMPRESSED_EN
  assign aligned = next_pc[0] == 1'b0;
  assign step    = inst_16 ? XLEN'(2) : XLEN'(INC_STEP);
`else
  assign aligned = next_pc[1:0] == 2'b00;
  assign step    = XLEN'(INC_STEP);
`endif

  always_comb begin
    nxt     = pc;
    mis_err = 1'b0;
    op_err  = 1'b0;
    mret_ok = 1'b0;
    unique case (1'b1)
      is_nop: nxt = pc;
      is_inc: nxt = pc + step;
      is_asg: begin
        if (aligned) nxt = next_pc;
        else mis_err = 1'b1;
      end
      is_rst: nxt = RESET_VEC;
      is_mret: begin
        if (in_handler) begin
          nxt     = epc;
          mret_ok = 1'b1;
        end else begin
          op_err  = 1'b1;
        end
      end
      default: op_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_seq.sv
// PC sequencer: PC/EPC registers, handler FSM, vectored interrupt entry.
// PC_SEQ_COMPRESSED_EN adds inst_16 and forces epc[0] to zero.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] INT_BASE   = XLEN'(DEF_INT_BASE),
  parameter int              NUM_INT    = DEF_NUM_INT,
  parameter int              VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int              INC_STEP   = DEF_INC_STEP,
  localparam int             IDW        = $clog2(NUM_INT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_OP_W-1:0] pc_op,
  input  logic [XLEN-1:0]    next_pc,
  input  logic               int_req,
  input  logic [IDW-1:0]     int_id,
  input  logic               int_en,
`ifdef PC_SEQ_COMPRESSED_EN
  input  logic               inst_16,
`endif
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    epc,
  output logic               in_handler,
  output logic               int_ack,
  output logic               misalign_err,
  output logic               op_err
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            ack_q, ack_d;
  logic            mis_q, mis_d;
  logic            oe_q, oe_d;

  logic [XLEN-1:0] nxt;
  logic [XLEN-1:0] vec_addr;
  logic            nxt_mis;
  logic            nxt_oe;
  logic            mret_ok;
  logic            is_rst;
  logic            take;

  pc_seq_nxt #(
    .XLEN      (XLEN),
    .INC_STEP  (INC_STEP),
    .RESET_VEC (RESET_VEC)
  ) u_nxt (
    .pc         (pc_q),
    .epc        (epc_q),
    .pc_op      (pc_op),
    .next_pc    (next_pc),
    .in_handler (state_q == ST_HANDLER),
`ifdef PC_SEQ_COMPRESSED_EN
    .inst_16    (inst_16),
`endif
    .nxt        (nxt),
    .mis_err    (nxt_mis),
    .op_err     (nxt_oe),
    .mret_ok    (mret_ok)
  );

  // int_id width already masks out-of-range sources
  assign vec_addr = INT_BASE + XLEN'(int_id) * XLEN'(VEC_STRIDE);
  assign is_rst   = pc_op == OP_RESET;
  assign take     = (state_q == ST_RUN) & int_req & int_en & ~is_rst;

  always_comb begin
    state_d = state_q;
    pc_d    = nxt;
    epc_d   = epc_q;
    ack_d   = 1'b0;
    mis_d   = nxt_mis;
    oe_d    = nxt_oe;
    unique case (1'b1)
      is_rst:  state_d = ST_RUN;
      take: begin
        state_d = ST_HANDLER;
`ifdef PC_SEQ_COMPRESSED_EN
        epc_d   = {nxt[XLEN-1:1], 1'b0};
`else
        epc_d   = nxt;
`endif
        pc_d    = vec_addr;
        ack_d   = 1'b1;
      end
      mret_ok: state_d = ST_RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      ack_q   <= 1'b0;
      mis_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ack_q   <= ack_d;
      mis_q   <= mis_d;
      oe_q    <= oe_d;
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign in_handler   = state_q == ST_HANDLER;
  assign int_ack      = ack_q;
  assign misalign_err = mis_q;
  assign op_err       = oe_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed scoreboard bench for pc_seq (default parameters).
// Covers reset, INC/wrap, ASSIGN alignment, interrupts, priority, errors.
module tb_pc_seq;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ih;
    logic        ack;
    logic        mis;
    logic        oe;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  pc_op;
  logic [31:0] next_pc;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_en;
`ifdef PC_SEQ_COMPRESSED_EN
  logic        inst_16;
`endif
  logic [31:0] pc;
  logic [31:0] epc;
  logic        in_handler;
  logic        int_ack;
  logic        misalign_err;
  logic        op_err;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  pc_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_op        (pc_op),
    .next_pc      (next_pc),
    .int_req      (int_req),
    .int_id       (int_id),
    .int_en       (int_en),
`ifdef PC_SEQ_COMPRESSED_EN
    .inst_16      (inst_16),
`endif
    .pc           (pc),
    .epc          (epc),
    .in_handler   (in_handler),
    .int_ack      (int_ack),
    .misalign_err (misalign_err),
    .op_err       (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] e,
                      input logic ih, input logic ack,
                      input logic mis, input logic oe);
    exp_t x;
    x.pc  = p;
    x.epc = e;
    x.ih  = ih;
    x.ack = ack;
    x.mis = mis;
    x.oe  = oe;
    q.push_back(x);
  endtask

  task automatic check(input string tag);
    exp_t x;
    total++;
    assert (q.size() > 0) else begin
      bad++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end
    if (q.size() > 0) begin
      x = q.pop_front();
      cmp({tag, ".pc"},  pc,                  x.pc);
      cmp({tag, ".epc"}, epc,                 x.epc);
      cmp({tag, ".ih"},  32'(in_handler),     32'(x.ih));
      cmp({tag, ".ack"}, 32'(int_ack),        32'(x.ack));
      cmp({tag, ".mis"}, 32'(misalign_err),   32'(x.mis));
      cmp({tag, ".oe"},  32'(op_err),         32'(x.oe));
    end
  endtask

  task automatic step(input string tag, input logic [2:0] op,
                      input logic [31:0] npc, input logic req,
                      input logic [2:0] id, input logic en,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_ih, input logic e_ack,
                      input logic e_mis, input logic e_oe);
    @(negedge clk);
    rst_n   = 1'b1;
    pc_op   = op;
    next_pc = npc;
    int_req = req;
    int_id  = id;
    int_en  = en;
    push(e_pc, e_epc, e_ih, e_ack, e_mis, e_oe);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    pc_op   = 3'b000;
    next_pc = '0;
    int_req = 1'b0;
    int_id  = '0;
    int_en  = 1'b0;
`ifdef PC_SEQ_COMPRESSED_EN
    inst_16 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    push(32'h0, 32'h0, 0, 0, 0, 0);
    check("reset");

    step("inc1", 3'b001, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0, 0);
    step("inc2", 3'b001, 0, 0, 0, 0, 32'h8, 0, 0, 0, 0, 0);
    step("inc3", 3'b001, 0, 0, 0, 0, 32'hC, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push(32'h0, 32'h0, 0, 0, 0, 0);
    check("async_rst");

    step("asg_ok",  3'b010, 32'h2000, 0, 0, 0, 32'h2000, 0, 0, 0, 0, 0);
    step("asg_mis", 3'b010, 32'h2002, 0, 0, 0, 32'h2000, 0, 0, 0, 1, 0);
    step("mis_end", 3'b000, 0,        0, 0, 0, 32'h2000, 0, 0, 0, 0, 0);
    step("asg_40",  3'b010, 32'h40,   0, 0, 0, 32'h40,   0, 0, 0, 0, 0);

    step("int_in",  3'b001, 0, 1, 3, 1, 32'h10C, 32'h44, 1, 1, 0, 0);
    step("nonest",  3'b000, 0, 1, 5, 1, 32'h10C, 32'h44, 1, 0, 0, 0);
    step("h_inc",   3'b001, 0, 0, 0, 1, 32'h110, 32'h44, 1, 0, 0, 0);
    step("mret",    3'b100, 0, 0, 0, 1, 32'h44,  32'h44, 0, 0, 0, 0);
    step("en_off",  3'b001, 0, 1, 2, 0, 32'h48,  32'h44, 0, 0, 0, 0);

    step("int_b",   3'b001, 0, 1, 1, 1, 32'h104, 32'h4C, 1, 1, 0, 0);
    step("mret_rq", 3'b100, 0, 1, 1, 1, 32'h4C,  32'h4C, 0, 0, 0, 0);
    step("after",   3'b000, 0, 1, 2, 1, 32'h108, 32'h4C, 1, 1, 0, 0);

    step("rst_op",  3'b011, 0, 1, 2, 1, 32'h0, 32'h4C, 0, 0, 0, 0);
    step("idle",    3'b000, 0, 0, 0, 1, 32'h0, 32'h4C, 0, 0, 0, 0);
    step("mret_run",3'b100, 0, 0, 0, 1, 32'h0, 32'h4C, 0, 0, 0, 1);
    step("op7",     3'b111, 0, 0, 0, 1, 32'h0, 32'h4C, 0, 0, 0, 1);
    step("op7_int", 3'b111, 0, 1, 0, 1, 32'h100, 32'h0, 1, 1, 0, 1);
    step("mret2",   3'b100, 0, 0, 0, 1, 32'h0,   32'h0, 0, 0, 0, 0);

    step("asg_top", 3'b010, 32'hFFFF_FFFC, 0, 0, 0,
         32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    step("wrap",    3'b001, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);

    step("inc4",    3'b001, 0, 0, 0, 0, 32'h4,   0,     0, 0, 0, 0);
    step("int7",    3'b000, 0, 1, 7, 1, 32'h11C, 32'h4, 1, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push(32'h0, 32'h0, 0, 0, 0, 0);
    check("rst_hdl");
    step("re_eval", 3'b000, 0, 1, 7, 1, 32'h11C, 32'h0, 1, 1, 0, 0);
    step("mret3",   3'b100, 0, 0, 0, 1, 32'h0,   32'h0, 0, 0, 0, 0);

`ifdef PC_SEQ_COMPRESSED_EN
    step("c_asg",   3'b010, 32'h100, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0);
    inst_16 = 1'b1;
    step("c_inc16", 3'b001, 0,       0, 0, 0, 32'h102, 0, 0, 0, 0, 0);
    inst_16 = 1'b0;
    step("c_inc32", 3'b001, 0,       0, 0, 0, 32'h106, 0, 0, 0, 0, 0);
    step("c_asg2",  3'b010, 32'h102, 0, 0, 0, 32'h102, 0, 0, 0, 0, 0);
    step("c_odd",   3'b010, 32'h103, 0, 0, 0, 32'h102, 0, 0, 0, 1, 0);
`else
    step("asg_half",3'b010, 32'h102, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
